// File: rtl/mill_modif_demod_pkg.sv
// -----------------------------------------------------------------------------
// mill_modif_pkg
// Shared types and helpers for the Modified-Miller pause decoder.
//   - sym_e          : symbol class of one bit period (X, Y, Z, or invalid)
//   - ETU_CYCLES_DEF : default clock cycles per bit period
//   - classify()     : maps the two half-ETU samples to a symbol
//   - sym_to_bit()   : maps a symbol to its decoded NRZ bit
// Optional feature macro used by the bundle: MILL_MODIF_ERR_EN.
// -----------------------------------------------------------------------------
package mill_modif_pkg;

    localparam int ETU_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        SYM_X,   // carrier, then pause  -> 1
        SYM_Y,   // pause, then carrier  -> 0
        SYM_Z,   // carrier throughout   -> 0
        SYM_ERR  // pause throughout     -> 0 (invalid)
    } sym_e;

    // a = level in the middle of the first half, b = middle of the second half.
    function automatic sym_e classify(input logic a, input logic b);
        case ({a, b})
            2'b10:   return SYM_X;
            2'b01:   return SYM_Y;
            2'b11:   return SYM_Z;
            default: return SYM_ERR;
        endcase
    endfunction

    function automatic logic sym_to_bit(input sym_e sym);
        return (sym == SYM_X);
    endfunction

endpackage

// File: rtl/mill_modif_demod_if.sv
// -----------------------------------------------------------------------------
// mill_modif_demod_if
// Signal bundle between the envelope source and the decoder.
//   in_enable : decoder enable, rising edge starts the ETU grid
//   in_data   : envelope, 0 = pause, 1 = carrier
//   out_data  : decoded bit, valid for one full ETU
//   out_err   : (only with MILL_MODIF_ERR_EN) invalid (0,0) symbol flag
// master = envelope source / consumer side, slave = decoder side.
// -----------------------------------------------------------------------------
interface mill_modif_demod_if;

    logic in_enable;
    logic in_data;
    logic out_data;
`ifdef MILL_MODIF_ERR_EN
    logic out_err;

    modport master (output in_enable, in_data, input  out_data, out_err);
    modport slave  (input  in_enable, in_data, output out_data, out_err);
`else
    modport master (output in_enable, in_data, input  out_data);
    modport slave  (input  in_enable, in_data, output out_data);
`endif

endinterface

// File: rtl/mill_modif_demod_etu_timer.sv
// -----------------------------------------------------------------------------
// mill_etu_timer
// Phase counter for the bit-period grid. The counter sits at 0 while disabled,
// so the first clock edge that sees enable = 1 is phase 0.
//   clk, rst      : clock, synchronous active-high reset
//   enable        : grid runs while high, clears the phase while low
//   sample_a_stb  : edge at phase H/2     (middle of first half-ETU)
//   sample_b_stb  : edge at phase H + H/2 (middle of second half-ETU)
//   etu_end_stb   : edge at phase ETU_CYCLES-1 (last cycle of the ETU)
// ETU_CYCLES must be even and >= 4.
// -----------------------------------------------------------------------------
module mill_etu_timer
    import mill_modif_pkg::*;
#(
    parameter int ETU_CYCLES = ETU_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic sample_a_stb,
    output logic sample_b_stb,
    output logic etu_end_stb
);

    localparam int              PW     = $clog2(ETU_CYCLES);
    localparam int              HALF   = ETU_CYCLES / 2;
    localparam logic [PW-1:0]   PH_A   = PW'(HALF / 2);
    localparam logic [PW-1:0]   PH_B   = PW'(HALF + HALF / 2);
    localparam logic [PW-1:0]   PH_END = PW'(ETU_CYCLES - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    always_comb begin
        // NOTE: give every always_comb output a default on entry so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        phase_d = phase_q + PW'(1);
        if (!enable || phase_q == PH_END) begin
            phase_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign sample_a_stb = enable && (phase_q == PH_A);
    assign sample_b_stb = enable && (phase_q == PH_B);
    assign etu_end_stb  = enable && (phase_q == PH_END);

endmodule

// File: rtl/mill_modif_demod.sv
// -----------------------------------------------------------------------------
// mill_modif_demod
// Modified-Miller (ISO 14443-A style) pause decoder. Samples the envelope in
// the middle of each half-ETU, classifies the bit period as X/Y/Z and
// registers the NRZ bit at the last cycle of the ETU, so the decoded bit is
// visible for the whole following ETU.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mill_modif_demod_if (in_enable, in_data,
//              out_data, and out_err when MILL_MODIF_ERR_EN is defined)
// Optional feature macro: MILL_MODIF_ERR_EN adds out_err, high for one ETU
// after an all-pause (0,0) symbol.
// in_data is not synchronized here; it must already be in the clk domain.
// -----------------------------------------------------------------------------
module mill_modif_demod
    import mill_modif_pkg::*;
#(
    parameter int ETU_CYCLES = ETU_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    mill_modif_demod_if.slave   bus
);

    logic sample_a_stb;
    logic sample_b_stb;
    logic etu_end_stb;

    mill_etu_timer #(
        .ETU_CYCLES (ETU_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .enable       (bus.in_enable),
        .sample_a_stb (sample_a_stb),
        .sample_b_stb (sample_b_stb),
        .etu_end_stb  (etu_end_stb)
    );

    logic sample_a_q, sample_a_d;
    logic sample_b_q, sample_b_d;
    logic out_data_q, out_data_d;
    logic b_now;
    sym_e sym;
`ifdef MILL_MODIF_ERR_EN
    logic out_err_q, out_err_d;
`endif

    always_comb begin
        // With ETU_CYCLES = 4 the second sample lands on the same edge as the
        // classification, so take the live input in that case.
        b_now      = sample_b_stb ? bus.in_data : sample_b_q;
        sym        = classify(sample_a_q, b_now);

        sample_a_d = sample_a_q;
        sample_b_d = sample_b_q;
        out_data_d = out_data_q;
`ifdef MILL_MODIF_ERR_EN
        out_err_d  = out_err_q;
`endif

        if (!bus.in_enable) begin
            // Disable discards any partial symbol and clears the output.
            sample_a_d = 1'b1;
            sample_b_d = 1'b1;
            out_data_d = 1'b0;
`ifdef MILL_MODIF_ERR_EN
            out_err_d  = 1'b0;
`endif
        end else begin
            if (sample_a_stb) sample_a_d = bus.in_data;
            if (sample_b_stb) sample_b_d = bus.in_data;
            if (etu_end_stb) begin
                out_data_d = sym_to_bit(sym);
`ifdef MILL_MODIF_ERR_EN
                out_err_d  = (sym == SYM_ERR);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_a_q <= 1'b1;
            sample_b_q <= 1'b1;
            out_data_q <= 1'b0;
`ifdef MILL_MODIF_ERR_EN
            out_err_q  <= 1'b0;
`endif
        end else begin
            sample_a_q <= sample_a_d;
            sample_b_q <= sample_b_d;
            out_data_q <= out_data_d;
`ifdef MILL_MODIF_ERR_EN
            out_err_q  <= out_err_d;
`endif
        end
    end

    assign bus.out_data = out_data_q;
`ifdef MILL_MODIF_ERR_EN
    assign bus.out_err  = out_err_q;
`endif

endmodule

// File: tb/tb_mill_modif_demod.sv
// -----------------------------------------------------------------------------
// tb_mill_modif_demod
// Directed bench for mill_modif_demod (ETU_CYCLES = 8). Each vector gives the
// two half-ETU envelope levels and the bit expected one ETU later.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Builds with or without MILL_MODIF_ERR_EN.
// -----------------------------------------------------------------------------
module tb_mill_modif_demod;
    import mill_modif_pkg::*;

    localparam int ETU = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mill_modif_demod_if bus();

    mill_modif_demod #(
        .ETU_CYCLES (ETU)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic h1;       // level during first half-ETU
        logic h2;       // level during second half-ETU
        logic exp_bit;  // decoded bit
        logic exp_err;  // invalid-symbol flag
    } vec_t;

    vec_t vecs [14];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic exp_bit;
    logic exp_err;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name);
        check(name, bus.out_data, exp_bit);
`ifdef MILL_MODIF_ERR_EN
        check({name, "_err"}, bus.out_err, exp_err);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Enable (if not already) and stream vectors first..last, one per ETU.
    // During each ETU the output must show the previous vector's result;
    // the first ETU after enabling shows 0.
    task automatic run_etus(input int first, input int last);
        exp_bit = 1'b0;
        exp_err = 1'b0;
        bus.in_enable = 1'b1;
        for (int i = first; i <= last; i++) begin
            for (int c = 0; c < ETU; c++) begin
                bus.in_data = (c < ETU / 2) ? vecs[i].h1 : vecs[i].h2;
                @(negedge clk);
                check_out($sformatf("v%0d_c%0d", i, c));
                cyc();
            end
            exp_bit = vecs[i].exp_bit;
            exp_err = vecs[i].exp_err;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0};  // X
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0};  // Z
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0};  // Y
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0};  // X
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};  // X
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0};  // Z
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0};  // Z
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1};  // invalid
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0};  // X
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0};  // idle carrier
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0};  // idle carrier
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0};  // idle carrier
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0};  // Y
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0};  // X

        rst           = 1'b1;
        bus.in_enable = 1'b0;
        bus.in_data   = 1'b1;
        exp_bit       = 1'b0;
        exp_err       = 1'b0;

        // Reset with the envelope toggling.
        cyc();
        for (int c = 0; c < 2; c++) begin
            bus.in_data = c[0];
            @(negedge clk);
            check_out($sformatf("rst_c%0d", c));
            check($sformatf("rst_phase_c%0d", c), dut.u_timer.phase_q == 3'd0, 1'b1);
            cyc();
        end
        rst = 1'b0;

        // Disabled, envelope toggling every 4 cycles.
        for (int c = 0; c < 16; c++) begin
            bus.in_data = ((c / 4) % 2) != 0;
            @(negedge clk);
            check_out($sformatf("dis_c%0d", c));
            cyc();
        end

        // Main symbol stream, including invalid and a trailing X.
        run_etus(0, 8);

        // Start an X symbol, drop enable at phase 3. Output still shows the
        // previous X until the edge that samples enable low.
        for (int c = 0; c < 3; c++) begin
            bus.in_data = 1'b1;
            @(negedge clk);
            check_out($sformatf("abort_pre_c%0d", c));
            cyc();
        end
        bus.in_enable = 1'b0;
        @(negedge clk);
        check_out("abort_edge");
        cyc();
        exp_bit = 1'b0;
        exp_err = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.in_data = c[0];
            @(negedge clk);
            check_out($sformatf("abort_post_c%0d", c));
            check($sformatf("abort_phase_c%0d", c), dut.u_timer.phase_q == 3'd0, 1'b1);
            cyc();
        end

        // Re-enable: idle carrier decodes to 0, then a fresh grid Y, X.
        run_etus(9, 13);

        // One more ETU of carrier to observe the final X.
        for (int c = 0; c < ETU; c++) begin
            bus.in_data = 1'b1;
            @(negedge clk);
            check_out($sformatf("tail_c%0d", c));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
